alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter REG_OUT, default 0; 0 = combinational outputs, 1 = one registered output stage.
REQ-002 clk  input  1  clock; rising edge; used only when REG_OUT=1.
REQ-003 resetn  input  1  reset, synchronous, active-low; used only when REG_OUT=1.
REQ-004 in_a  input  32  operand A (rs1, or PC for JAL/JALR/AUIPC).
REQ-005 in_b  input  32  operand B (rs2, immediate, or constant 4).
REQ-006 inst  input  32  full RV32I instruction word; opcode inst[6:0], funct3 inst[14:12], funct7 bit inst[30].
REQ-007 result  output  32  arithmetic/logic result.
REQ-008 take_b  output  1  branch-condition-true flag.

Function
REQ-009 With REG_OUT=0, outputs SHALL be purely combinational from in_a, in_b and inst, with zero-cycle latency.
REQ-010 For opcode OP (0110011) and OP-IMM (0010011), funct3 SHALL select: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
REQ-011 funct3=000 SHALL subtract (in_a - in_b) only when opcode is OP and inst[30]=1; OP-IMM SHALL always add.
REQ-012 funct3=101 SHALL perform arithmetic right shift when inst[30]=1, logical otherwise, for both OP and OP-IMM.
REQ-013 Shift amount SHALL be in_b[4:0]; in_b[31:5] SHALL be ignored by shifts.
REQ-014 SLT SHALL return 1 when in_a < in_b as signed 32-bit values, else 0; SLTU uses unsigned comparison; result bits [31:1] SHALL be 0.
REQ-015 For every other opcode (JAL, JALR, AUIPC, LUI, LOAD, STORE, BRANCH, SYSTEM, unknown), result SHALL be in_a + in_b modulo 2^32.
REQ-016 Add and subtract SHALL wrap modulo 2^32; no overflow or carry output.
REQ-017 take_b SHALL be 0 unless opcode is BRANCH (1100011).
REQ-018 For BRANCH, take_b by funct3: 000 in_a==in_b; 001 in_a!=in_b; 100 signed in_a<in_b; 101 signed in_a>=in_b; 110 unsigned in_a<in_b; 111 unsigned in_a>=in_b; 010/011 SHALL give 0.
REQ-019 Signed/unsigned less-than SHALL be derived from one 33-bit subtraction shared with SUB, SLT, SLTU and branch compares.
REQ-020 Unknown/illegal encodings SHALL produce defined values (no X); no exception signalling.
REQ-021 With REG_OUT=1, result and take_b SHALL be registered, one cycle latency, updated every rising clk edge.

Reset
REQ-022 With REG_OUT=1, resetn=0 at a rising edge SHALL force result=0 and take_b=0; reset asserted mid-stream overrides the new computation that cycle.
REQ-023 With REG_OUT=0, resetn SHALL have no effect on outputs.

Structure
REQ-024 Opcode constants (OP, OP_IMM, BRANCH, LUI, AUIPC, JAL, JALR, LOAD, STORE, SYSTEM) and funct3 codes SHALL live in a shared package used also by imm_mux and the core.
REQ-025 Immediate generation SHALL NOT be in alu; it belongs to sibling block imm_mux.
REQ-026 One sub-module alu_shifter (32-bit barrel shifter, left/logical-right/arithmetic-right) is natural; all else inline.

Verification
REQ-027 OP ADD/SUB: in_a=0x00000005, in_b=0x00000007, inst=SUB (funct7=0100000) -> result=0xFFFFFFFE; same with OP-IMM and inst[30]=1 -> result=0x0000000C.
REQ-028 SRA vs SRL: in_a=0x80000000, in_b=0x00000004 -> SRA result=0xF8000000, SRL result=0x08000000; in_b=0x00000024 -> shift by 4.
REQ-029 SLT/SLTU: in_a=0xFFFFFFFF, in_b=0x00000001 -> SLT=1, SLTU=0.
REQ-030 Branches: in_a=0xFFFFFFFF, in_b=0x00000001 -> BLT=1, BGE=0, BLTU=0, BGEU=1, BEQ=0, BNE=1; funct3=010 -> 0.
REQ-031 Non-ALU opcode: JAL with in_a=0x00001000, in_b=4 -> result=0x00001004, take_b=0; ADD 0xFFFFFFFF+1 -> 0x00000000.
REQ-032 REG_OUT=1: ADD applied cycle N -> result valid after edge N+1; resetn=0 at an edge -> result=0, take_b=0 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared RV32I encodings for the ALU, imm_mux and core.
// Also holds the shift-direction select type used by alu_shifter.
package alu_pkg;

  typedef enum logic [6:0] {
    LOAD   = 7'b0000011,
    OP_IMM = 7'b0010011,
    AUIPC  = 7'b0010111,
    STORE  = 7'b0100011,
    OP     = 7'b0110011,
    LUI    = 7'b0110111,
    BRANCH = 7'b1100011,
    JALR   = 7'b1100111,
    JAL    = 7'b1101111,
    SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    F3_ADD_SUB = 3'b000,
    F3_SLL     = 3'b001,
    F3_SLT     = 3'b010,
    F3_SLTU    = 3'b011,
    F3_XOR     = 3'b100,
    F3_SRL_SRA = 3'b101,
    F3_OR      = 3'b110,
    F3_AND     = 3'b111
  } alu_f3_e;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_f3_e;

  typedef enum logic [1:0] {
    SH_LL,
    SH_RL,
    SH_RA
  } shift_op_e;

endpackage

// File: rtl/alu_shifter.sv
// 32-bit barrel shifter: left logical, right logical, right arithmetic.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [31:0] data,
  input  logic [4:0]  shamt,
  input  shift_op_e   op,
  output logic [31:0] dout
);

  always_comb begin
    dout = data;
    case (op)
      SH_LL:   dout = data << shamt;
      SH_RL:   dout = data >> shamt;
      SH_RA:   dout = $signed(data) >>> shamt;
      default: dout = data;
    endcase
  end

endmodule

// File: rtl/alu.sv
// RV32I integer ALU with branch-condition flag; optional registered output stage.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned REG_OUT = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [31:0] inst,
  output logic [31:0] result,
  output logic        take_b
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        alt;
  logic [32:0] diff;
  logic [31:0] sum;
  logic        ltu;
  logic        lts;
  logic        eq;
  shift_op_e   sh_op;
  logic [31:0] sh_out;
  logic [31:0] res_c;
  logic        take_c;
  logic        unused_inst;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign alt    = inst[30];
  assign unused_inst = &{1'b0, inst[31], inst[29:15], inst[11:7]};

  // Single 33-bit subtract feeds SUB, SLT/SLTU and every branch compare.
  assign diff = {1'b0, in_a} - {1'b0, in_b};
  assign sum  = in_a + in_b;
  assign ltu  = diff[32];
  assign lts  = (in_a[31] != in_b[31]) ? in_a[31] : diff[32];
  assign eq   = (diff[31:0] == '0);

  assign sh_op = !f3[2] ? SH_LL : (alt ? SH_RA : SH_RL);

  alu_shifter u_shifter (
    .data  (in_a),
    .shamt (in_b[4:0]),
    .op    (sh_op),
    .dout  (sh_out)
  );

  always_comb begin
    res_c  = sum;
    take_c = 1'b0;
    if (opcode == OP || opcode == OP_IMM) begin
      case (f3)
        F3_ADD_SUB: res_c = (opcode == OP && alt) ? diff[31:0] : sum;
        F3_SLL:     res_c = sh_out;
        F3_SLT:     res_c = {31'b0, lts};
        F3_SLTU:    res_c = {31'b0, ltu};
        F3_XOR:     res_c = in_a ^ in_b;
        F3_SRL_SRA: res_c = sh_out;
        F3_OR:      res_c = in_a | in_b;
        F3_AND:     res_c = in_a & in_b;
        default:    res_c = sum;
      endcase
    end
    if (opcode == BRANCH) begin
      case (f3)
        F3_BEQ:  take_c = eq;
        F3_BNE:  take_c = !eq;
        F3_BLT:  take_c = lts;
        F3_BGE:  take_c = !lts;
        F3_BLTU: take_c = ltu;
        F3_BGEU: take_c = !ltu;
        default: take_c = 1'b0;
      endcase
    end
  end

  if (REG_OUT != 0) begin : g_reg
    always_ff @(posedge clk) begin
      if (!resetn) begin
        result <= '0;
        take_b <= 1'b0;
      end else begin
        result <= res_c;
        take_b <= take_c;
      end
    end
  end else begin : g_comb
    logic unused_clk;
    assign unused_clk = &{1'b0, clk, resetn};
    assign result = res_c;
    assign take_b = take_c;
  end

endmodule

// File: tb/tb_alu.sv
// Bench for alu: combinational and registered instances against a behavioural model.
module tb_alu;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [31:0] inst = '0;
  logic [31:0] c_res, r_res;
  logic        c_tb, r_tb;
  int          total = 0;
  int          bad = 0;

  localparam logic [6:0] M_OP     = 7'b0110011;
  localparam logic [6:0] M_OPIMM  = 7'b0010011;
  localparam logic [6:0] M_BR     = 7'b1100011;
  localparam logic [6:0] M_JAL    = 7'b1101111;
  localparam logic [6:0] M_JALR   = 7'b1100111;
  localparam logic [6:0] M_LUI    = 7'b0110111;
  localparam logic [6:0] M_AUIPC  = 7'b0010111;
  localparam logic [6:0] M_LOAD   = 7'b0000011;
  localparam logic [6:0] M_STORE  = 7'b0100011;
  localparam logic [6:0] M_SYSTEM = 7'b1110011;

  alu #(.REG_OUT(0)) u_comb (
    .clk(clk), .resetn(resetn), .in_a(in_a), .in_b(in_b), .inst(inst),
    .result(c_res), .take_b(c_tb)
  );

  alu #(.REG_OUT(1)) u_reg (
    .clk(clk), .resetn(resetn), .in_a(in_a), .in_b(in_b), .inst(inst),
    .result(r_res), .take_b(r_tb)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3, input logic b30);
    return {1'b0, b30, 15'h0, f3, 5'h0, opc};
  endfunction

  function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b, input logic [31:0] i);
    logic [6:0]  opc = i[6:0];
    logic [4:0]  sh  = b[4:0];
    logic [31:0] r;
    if (opc == M_OP || opc == M_OPIMM) begin
      case (i[14:12])
        3'd0: return (opc == M_OP && i[30]) ? a - b : a + b;
        3'd1: return a << sh;
        3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: return (a < b) ? 32'd1 : 32'd0;
        3'd4: return a ^ b;
        3'd5: begin
          if (i[30]) r = $signed(a) >>> sh;
          else       r = a >> sh;
          return r;
        end
        3'd6: return a | b;
        default: return a & b;
      endcase
    end
    return a + b;
  endfunction

  function automatic logic model_take(input logic [31:0] a, input logic [31:0] b, input logic [31:0] i);
    if (i[6:0] != M_BR) return 1'b0;
    case (i[14:12])
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model of the registered instance: value the outputs must hold after each edge.
  logic [31:0] exp_r_res;
  logic        exp_r_tb;
  logic        r_valid = 1'b0;

  always @(posedge clk) begin
    exp_r_res <= resetn ? model_res(in_a, in_b, inst) : '0;
    exp_r_tb  <= resetn ? model_take(in_a, in_b, inst) : 1'b0;
    r_valid   <= 1'b1;
  end

  always @(negedge clk) begin
    chk("model_comb_result", c_res, model_res(in_a, in_b, inst));
    chk("model_comb_take", {31'b0, c_tb}, {31'b0, model_take(in_a, in_b, inst)});
    if (r_valid) begin
      chk("model_reg_result", r_res, exp_r_res);
      chk("model_reg_take", {31'b0, r_tb}, {31'b0, exp_r_tb});
    end
  end

  task automatic apply(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] i, input logic [31:0] er, input logic et);
    @(posedge clk); #1;
    in_a = a; in_b = b; inst = i;
    @(negedge clk); #1;
    chk({name, "_comb_res"}, c_res, er);
    chk({name, "_comb_take"}, {31'b0, c_tb}, {31'b0, et});
    @(posedge clk); #1;
    chk({name, "_reg_res"}, r_res, er);
    chk({name, "_reg_take"}, {31'b0, r_tb}, {31'b0, et});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] opcs [12];
    opcs = '{M_OP, M_OP, M_OPIMM, M_OPIMM, M_BR, M_BR, M_JAL, M_JALR,
             M_LUI, M_AUIPC, M_LOAD, M_STORE};

    // Reset held: registered outputs zero, combinational outputs unaffected.
    resetn = 1'b0;
    in_a = 32'd5; in_b = 32'd7; inst = mk(M_OP, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_reg_res", r_res, 32'h0);
    chk("reset_reg_take", {31'b0, r_tb}, 32'h0);
    chk("reset_comb_res", c_res, 32'h0000000C);
    @(posedge clk); #1;
    resetn = 1'b1;

    apply("sub",      32'h5, 32'h7, mk(M_OP, 3'd0, 1'b1),    32'hFFFFFFFE, 1'b0);
    apply("addi_b30", 32'h5, 32'h7, mk(M_OPIMM, 3'd0, 1'b1), 32'h0000000C, 1'b0);
    apply("add_wrap", 32'hFFFFFFFF, 32'h1, mk(M_OP, 3'd0, 1'b0), 32'h0, 1'b0);
    apply("sra",      32'h80000000, 32'h4,  mk(M_OP, 3'd5, 1'b1), 32'hF8000000, 1'b0);
    apply("srl",      32'h80000000, 32'h4,  mk(M_OP, 3'd5, 1'b0), 32'h08000000, 1'b0);
    apply("sra_hi",   32'h80000000, 32'h24, mk(M_OP, 3'd5, 1'b1), 32'hF8000000, 1'b0);
    apply("srai_hi",  32'h80000000, 32'h24, mk(M_OPIMM, 3'd5, 1'b1), 32'hF8000000, 1'b0);
    apply("sll31",    32'h1, 32'h3F, mk(M_OP, 3'd1, 1'b0), 32'h80000000, 1'b0);
    apply("slt",      32'hFFFFFFFF, 32'h1, mk(M_OP, 3'd2, 1'b0), 32'h1, 1'b0);
    apply("sltu",     32'hFFFFFFFF, 32'h1, mk(M_OP, 3'd3, 1'b0), 32'h0, 1'b0);
    apply("xor",      32'hF0F0F0F0, 32'h0FF00FF0, mk(M_OP, 3'd4, 1'b0), 32'hFF00FF00, 1'b0);
    apply("or",       32'hF0F0F0F0, 32'h0FF00FF0, mk(M_OP, 3'd6, 1'b0), 32'hFFF0FFF0, 1'b0);
    apply("and",      32'hF0F0F0F0, 32'h0FF00FF0, mk(M_OP, 3'd7, 1'b0), 32'h00F000F0, 1'b0);
    apply("blt",      32'hFFFFFFFF, 32'h1, mk(M_BR, 3'd4, 1'b0), 32'h0, 1'b1);
    apply("bge",      32'hFFFFFFFF, 32'h1, mk(M_BR, 3'd5, 1'b0), 32'h0, 1'b0);
    apply("bltu",     32'hFFFFFFFF, 32'h1, mk(M_BR, 3'd6, 1'b0), 32'h0, 1'b0);
    apply("bgeu",     32'hFFFFFFFF, 32'h1, mk(M_BR, 3'd7, 1'b0), 32'h0, 1'b1);
    apply("beq_ne",   32'hFFFFFFFF, 32'h1, mk(M_BR, 3'd0, 1'b0), 32'h0, 1'b0);
    apply("bne",      32'hFFFFFFFF, 32'h1, mk(M_BR, 3'd1, 1'b0), 32'h0, 1'b1);
    apply("br_f3_2",  32'hFFFFFFFF, 32'h1, mk(M_BR, 3'd2, 1'b0), 32'h0, 1'b0);
    apply("beq_eq",   32'h7, 32'h7, mk(M_BR, 3'd0, 1'b0), 32'hE, 1'b1);
    apply("jal",      32'h00001000, 32'h4, mk(M_JAL, 3'd0, 1'b0), 32'h00001004, 1'b0);
    apply("lui",      32'h0, 32'h12345000, mk(M_LUI, 3'd0, 1'b0), 32'h12345000, 1'b0);

    // Reset asserted mid-stream overrides a taken branch.
    @(posedge clk); #1;
    in_a = 32'h1; in_b = 32'h2; inst = mk(M_BR, 3'd1, 1'b0); resetn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_reg_res", r_res, 32'h0);
    chk("midrst_reg_take", {31'b0, r_tb}, 32'h0);
    chk("midrst_comb_take", {31'b0, c_tb}, 32'h1);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("postrst_reg_res", r_res, 32'h3);
    chk("postrst_reg_take", {31'b0, r_tb}, 32'h1);

    // Random traffic; every cycle checked against the model.
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      inst       = $urandom;
      inst[6:0]  = (n % 16 == 15) ? 7'($urandom) : opcs[$urandom_range(0, 11)];
      in_a       = $urandom;
      in_b       = ($urandom_range(0, 7) == 0) ? in_a : 32'($urandom);
      if ($urandom_range(0, 3) == 0) in_b[31] = ~in_a[31];
      resetn     = ($urandom_range(0, 19) != 0);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
